// File: rtl/inst_mem_ctrl.sv
// Instruction memory with a streaming load port and a pipelined fetch port.
// The load port fills the array word by word; the fetch port serves the CPU
// with a fixed READ_LAT-cycle response and flags misaligned or unloaded
// addresses. Mode changes from RUN back to LOAD wait for in-flight fetches.
module inst_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  input  logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        fetch_inst,
  output logic                     fetch_err,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state_q;
  // Write pointer; it doubles as the loaded-word count since both start at
  // zero with every session and advance together on each accepted beat.
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Response pipeline: stage 0 is loaded at the accepting edge, the last
  // stage drives the fetch outputs directly.
  logic [READ_LAT-1:0] vld_q;
  logic                err_q [READ_LAT];
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  logic                beat;
  logic                accept;
  logic                req_err;
  logic                pend;
  logic [IDX_W-1:0]    idx;

  // Pointer reaching DEPTH sets the top count bit, which closes the port.
  assign load_ready  = (state_q == S_LOAD) && !cnt_q[CNT_W-1];
  assign fetch_ready = (state_q == S_RUN);
  assign busy        = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign load_count  = cnt_q;

  // A restart in the same cycle as a beat discards the beat.
  assign beat   = load_valid && load_ready && !load_start;
  assign accept = fetch_req && fetch_ready;

  assign idx     = fetch_addr[IDX_W+1:2];
  assign req_err = (fetch_addr[1:0] != 2'b00) ||
                   ({1'b0, idx} >= cnt_q) ||
                   ((fetch_addr >> (IDX_W + 2)) != '0);

  // Responses still needing at least one more edge before they are visible.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < READ_LAT - 1; i++) begin
      pend = pend | vld_q[i];
    end
  end

  // Mode FSM and load pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            cnt_q <= '0;
          end else begin
            if (beat) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_done) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (load_start) begin
            // A request accepted now is only in flight if it needs more edges.
            if (pend || (READ_LAT > 1 && accept)) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_LOAD;
              cnt_q   <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (!pend) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[cnt_q[IDX_W-1:0]] <= load_data;
    end
  end

  // Fetch response pipeline; error responses carry a zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept && req_err;
      dat_q[0] <= (accept && !req_err) ? mem[idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign fetch_valid = vld_q[READ_LAT-1];
  assign fetch_err   = err_q[READ_LAT-1];
  assign fetch_inst  = dat_q[READ_LAT-1];

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: two instances share all inputs, one with
// DEPTH=256/READ_LAT=1 and one with DEPTH=4/READ_LAT=3. Expected responses
// come from a word-array model and the address rules.
module tb_inst_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_done = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] load_data = '0;
  logic [31:0] fetch_addr = '0;

  logic        a_load_ready, a_fetch_ready, a_fetch_valid, a_fetch_err, a_busy;
  logic [8:0]  a_load_count;
  logic [31:0] a_fetch_inst;
  logic        b_load_ready, b_fetch_ready, b_fetch_valid, b_fetch_err, b_busy;
  logic [2:0]  b_load_count;
  logic [31:0] b_fetch_inst;

  inst_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .READ_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(a_load_ready), .load_done(load_done),
    .load_count(a_load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(a_fetch_ready), .fetch_valid(a_fetch_valid),
    .fetch_inst(a_fetch_inst), .fetch_err(a_fetch_err), .busy(a_busy)
  );

  inst_mem_ctrl #(.DATA_W(32), .DEPTH(4), .ADDR_W(32), .READ_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(b_load_ready), .load_done(load_done),
    .load_count(b_load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(b_fetch_ready), .fetch_valid(b_fetch_valid),
    .fetch_inst(b_fetch_inst), .fetch_err(b_fetch_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] inst;
  } resp_t;

  resp_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  resp_t mon_r;

  // Response recorder (no judgement here; tasks compare the logs).
  always @(negedge clk) begin
    if (a_fetch_valid) begin
      mon_r.cyc = cyc; mon_r.err = a_fetch_err; mon_r.inst = a_fetch_inst;
      obs_a.push_back(mon_r);
    end
    if (b_fetch_valid) begin
      mon_r.cyc = cyc; mon_r.err = b_fetch_err; mon_r.inst = b_fetch_inst;
      obs_b.push_back(mon_r);
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: word arrays, loaded counts and current mode.
  logic [31:0] m_a [256];
  logic [31:0] m_b [4];
  int          cnt_a = 0;
  int          cnt_b = 0;
  bit          in_load = 1'b0;
  bit          in_run = 1'b0;

  function automatic logic [32:0] model_a(input logic [31:0] addr);
    int w;
    w = int'(addr >> 2);
    if (addr[1:0] != 2'b00 || w >= cnt_a) return {1'b1, 32'h0};
    return {1'b0, m_a[w[7:0]]};
  endfunction

  function automatic logic [32:0] model_b(input logic [31:0] addr);
    int w;
    w = int'(addr >> 2);
    if (addr[1:0] != 2'b00 || w >= cnt_b) return {1'b1, 32'h0};
    return {1'b0, m_b[w[1:0]]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    in_load = 1'b1; in_run = 1'b0; cnt_a = 0; cnt_b = 0;
  endtask

  task automatic beat(input logic [31:0] d, input bit done);
    load_valid = 1'b1; load_data = d; load_done = done;
    if (in_load) begin
      if (cnt_a < 256) begin m_a[cnt_a[7:0]] = d; cnt_a++; end
      if (cnt_b < 4) begin m_b[cnt_b[1:0]] = d; cnt_b++; end
    end
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    if (done && in_load) begin in_load = 1'b0; in_run = 1'b1; end
  endtask

  task automatic done_pulse();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    if (in_load) begin in_load = 1'b0; in_run = 1'b1; end
  endtask

  task automatic issue(input logic [31:0] addr);
    resp_t       e;
    logic [32:0] r;
    fetch_req = 1'b1; fetch_addr = addr;
    if (in_run) begin
      r = model_a(addr); e.cyc = cyc + 1; e.err = r[32]; e.inst = r[31:0];
      exp_a.push_back(e);
      r = model_b(addr); e.cyc = cyc + 3; e.err = r[32]; e.inst = r[31:0];
      exp_b.push_back(e);
    end
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_load_ready, a_fetch_ready, a_fetch_valid, a_fetch_err, a_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags_a: got %b, expected 00000",
                         {a_load_ready, a_fetch_ready, a_fetch_valid, a_fetch_err, a_busy});
    end
    checks++;
    if ({b_load_ready, b_fetch_ready, b_fetch_valid, b_fetch_err, b_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags_b: got %b, expected 00000",
                         {b_load_ready, b_fetch_ready, b_fetch_valid, b_fetch_err, b_busy});
    end
    checks++;
    if (a_fetch_inst !== 32'h0 || b_fetch_inst !== 32'h0) begin
      errors++; $display("FAIL reset_inst: got %08h/%08h, expected 0", a_fetch_inst, b_fetch_inst);
    end
    checks++;
    if (a_load_count !== 9'd0 || b_load_count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d/%0d, expected 0", a_load_count, b_load_count);
    end
    rst_n = 1'b1;
    tick();
    start_load();
    for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
    checks++;
    if (a_load_count !== 9'd3 || a_busy !== 1'b1) begin
      errors++; $display("FAIL midload_count: got %0d busy=%b, expected 3 busy=1", a_load_count, a_busy);
    end
    rst_n = 1'b0;
    #1;
    in_load = 1'b0; in_run = 1'b0; cnt_a = 0; cnt_b = 0;
    checks++;
    if (a_load_count !== 9'd0 || b_load_count !== 3'd0 || a_busy !== 1'b0 || a_load_ready !== 1'b0) begin
      errors++; $display("FAIL midload_reset: got count=%0d busy=%b ready=%b, expected 0 0 0",
                         a_load_count, a_busy, a_load_ready);
    end
    clear_q();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({a_fetch_valid, b_fetch_valid, a_fetch_ready, b_fetch_ready, a_busy} !== 5'b0) begin
        errors++; $display("FAIL post_reset_idle[%0d]: got %b, expected 00000", i,
                           {a_fetch_valid, b_fetch_valid, a_fetch_ready, b_fetch_ready, a_busy});
      end
    end
  endtask

  task automatic test_load_fetch();
    start_load();
    checks++;
    if (a_load_ready !== 1'b1 || a_load_count !== 9'd0) begin
      errors++; $display("FAIL lf_open: got ready=%b count=%0d, expected 1 0", a_load_ready, a_load_count);
    end
    beat(32'h00500093, 1'b0);
    beat(32'h00100113, 1'b0);
    beat(32'h002081B3, 1'b0);
    checks++;
    if (a_load_count !== 9'd3) begin
      errors++; $display("FAIL lf_count: got %0d, expected 3", a_load_count);
    end
    done_pulse();
    checks++;
    if (a_fetch_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL lf_run: got ready=%b busy=%b, expected 1 0", a_fetch_ready, a_busy);
    end
    clear_q();
    issue(32'h0); issue(32'h4); issue(32'h8);
    tick();
    issue(32'hC);
    repeat (5) tick();
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++; $display("FAIL lf_nresp: got %0d, expected %0d", obs_a.size(), exp_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (obs_a[i].cyc !== exp_a[i].cyc || obs_a[i].err !== exp_a[i].err || obs_a[i].inst !== exp_a[i].inst) begin
        errors++; $display("FAIL lf_resp[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_a[i].cyc, obs_a[i].err, obs_a[i].inst, exp_a[i].cyc, exp_a[i].err, exp_a[i].inst);
      end
    end
  endtask

  task automatic test_misalign();
    clear_q();
    issue(32'h6); issue(32'h400); issue(32'h1); issue(32'h8000_0000);
    issue(32'h8); issue(32'h402);
    repeat (5) tick();
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++; $display("FAIL mis_nresp: got %0d, expected %0d", obs_a.size(), exp_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (obs_a[i].cyc !== exp_a[i].cyc || obs_a[i].err !== exp_a[i].err || obs_a[i].inst !== exp_a[i].inst) begin
        errors++; $display("FAIL mis_resp[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_a[i].cyc, obs_a[i].err, obs_a[i].inst, exp_a[i].cyc, exp_a[i].err, exp_a[i].inst);
      end
    end
  endtask

  task automatic test_full();
    int exp_cnt;
    repeat (4) tick();
    start_load();
    checks++;
    if (b_load_ready !== 1'b1 || a_load_ready !== 1'b1 || b_fetch_ready !== 1'b0) begin
      errors++; $display("FAIL full_direct_load: got b_rdy=%b a_rdy=%b b_frdy=%b, expected 1 1 0",
                         b_load_ready, a_load_ready, b_fetch_ready);
    end
    for (int k = 0; k < 5; k++) begin
      beat($urandom, 1'b0);
      exp_cnt = (k + 1 < 4) ? k + 1 : 4;
      checks++;
      if (b_load_ready !== (k + 1 < 4) || b_load_count !== 3'(exp_cnt)) begin
        errors++; $display("FAIL full_beat[%0d]: got ready=%b count=%0d, expected ready=%b count=%0d",
                           k, b_load_ready, b_load_count, (k + 1 < 4), exp_cnt);
      end
    end
    checks++;
    if (a_load_count !== 9'd5) begin
      errors++; $display("FAIL full_a_count: got %0d, expected 5", a_load_count);
    end
    done_pulse();
    checks++;
    if (b_fetch_ready !== 1'b1) begin
      errors++; $display("FAIL full_run: got fetch_ready=%b, expected 1", b_fetch_ready);
    end
    clear_q();
    for (int i = 0; i < 5; i++) issue(32'(4 * i));
    repeat (6) tick();
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL full_nresp: got %0d, expected %0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      checks++;
      if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].err !== exp_b[i].err || obs_b[i].inst !== exp_b[i].inst) begin
        errors++; $display("FAIL full_resp[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_b[i].cyc, obs_b[i].err, obs_b[i].inst, exp_b[i].cyc, exp_b[i].err, exp_b[i].inst);
      end
    end
  endtask

  task automatic test_drain();
    int n;
    repeat (4) tick();
    clear_q();
    issue(32'h4); issue(32'h8);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    in_load = 1'b1; in_run = 1'b0; cnt_a = 0; cnt_b = 0;
    n = 0;
    while (b_load_ready !== 1'b1 && n < 10) begin
      checks++;
      if (b_fetch_ready !== 1'b0 || b_busy !== 1'b1) begin
        errors++; $display("FAIL drain_flags[%0d]: got fetch_ready=%b busy=%b, expected 0 1", n, b_fetch_ready, b_busy);
      end
      tick();
      n++;
    end
    checks++;
    if (n < 1 || n > 3) begin
      errors++; $display("FAIL drain_len: got %0d cycles before LOAD, expected 1..3", n);
    end
    checks++;
    if (b_fetch_ready !== 1'b0 || b_load_count !== 3'd0) begin
      errors++; $display("FAIL drain_load: got fetch_ready=%b count=%0d, expected 0 0", b_fetch_ready, b_load_count);
    end
    repeat (4) tick();
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL drain_nresp: got %0d, expected %0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      checks++;
      if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].err !== exp_b[i].err || obs_b[i].inst !== exp_b[i].inst) begin
        errors++; $display("FAIL drain_resp[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_b[i].cyc, obs_b[i].err, obs_b[i].inst, exp_b[i].cyc, exp_b[i].err, exp_b[i].inst);
      end
    end
  endtask

  task automatic test_simultaneous();
    beat($urandom, 1'b0);
    beat($urandom, 1'b0);
    beat($urandom, 1'b1);
    checks++;
    if (a_load_count !== 9'd3 || b_load_count !== 3'd3 || a_fetch_ready !== 1'b1 || b_fetch_ready !== 1'b1) begin
      errors++; $display("FAIL simul_state: got counts %0d/%0d ready %b/%b, expected 3/3 1/1",
                         a_load_count, b_load_count, a_fetch_ready, b_fetch_ready);
    end
    clear_q();
    issue(32'h0); issue(32'h4); issue(32'h8);
    repeat (5) tick();
    checks++;
    if (obs_a.size() != exp_a.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL simul_nresp: got %0d/%0d, expected %0d/%0d",
                         obs_a.size(), obs_b.size(), exp_a.size(), exp_b.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (obs_a[i].cyc !== exp_a[i].cyc || obs_a[i].err !== exp_a[i].err || obs_a[i].inst !== exp_a[i].inst) begin
        errors++; $display("FAIL simul_resp_a[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_a[i].cyc, obs_a[i].err, obs_a[i].inst, exp_a[i].cyc, exp_a[i].err, exp_a[i].inst);
      end
    end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      checks++;
      if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].err !== exp_b[i].err || obs_b[i].inst !== exp_b[i].inst) begin
        errors++; $display("FAIL simul_resp_b[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                           i, obs_b[i].cyc, obs_b[i].err, obs_b[i].inst, exp_b[i].cyc, exp_b[i].err, exp_b[i].inst);
      end
    end
  endtask

  task automatic test_random();
    int          n;
    int          r;
    logic [31:0] addr;
    for (int round = 0; round < 4; round++) begin
      repeat (5) tick();
      start_load();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        if (i == 2 && $urandom_range(0, 2) == 0) start_load();
        beat($urandom, 1'b0);
      end
      done_pulse();
      done_pulse();
      checks++;
      if (a_fetch_ready !== 1'b1 || a_load_count !== 9'(cnt_a) || b_load_count !== 3'(cnt_b)) begin
        errors++; $display("FAIL rnd_run[%0d]: got ready=%b counts %0d/%0d, expected 1 %0d/%0d",
                           round, a_fetch_ready, a_load_count, b_load_count, cnt_a, cnt_b);
      end
      clear_q();
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 9);
          if (r < 7)       addr = 32'(4 * $urandom_range(0, 15));
          else if (r == 7) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
          else if (r == 8) addr = $urandom;
          else             addr = 32'(4 * $urandom_range(0, 300));
          issue(addr);
        end else begin
          tick();
        end
      end
      repeat (5) tick();
      checks++;
      if (obs_a.size() != exp_a.size() || obs_b.size() != exp_b.size()) begin
        errors++; $display("FAIL rnd_nresp[%0d]: got %0d/%0d, expected %0d/%0d", round,
                           obs_a.size(), obs_b.size(), exp_a.size(), exp_b.size());
      end
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
        checks++;
        if (obs_a[i].cyc !== exp_a[i].cyc || obs_a[i].err !== exp_a[i].err || obs_a[i].inst !== exp_a[i].inst) begin
          errors++; $display("FAIL rnd_resp_a[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                             i, obs_a[i].cyc, obs_a[i].err, obs_a[i].inst, exp_a[i].cyc, exp_a[i].err, exp_a[i].inst);
        end
      end
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
        checks++;
        if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].err !== exp_b[i].err || obs_b[i].inst !== exp_b[i].inst) begin
          errors++; $display("FAIL rnd_resp_b[%0d]: got cyc=%0d err=%b inst=%08h, expected cyc=%0d err=%b inst=%08h",
                             i, obs_b[i].cyc, obs_b[i].err, obs_b[i].inst, exp_b[i].cyc, exp_b[i].err, exp_b[i].inst);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    clear_q();
    issue(32'h0); issue(32'h4);
    rst_n = 1'b0;
    #1;
    in_load = 1'b0; in_run = 1'b0; cnt_a = 0; cnt_b = 0;
    clear_q();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    checks++;
    if (obs_a.size() != 0 || obs_b.size() != 0) begin
      errors++; $display("FAIL inflight_discard: got %0d/%0d responses, expected 0/0", obs_a.size(), obs_b.size());
    end
    checks++;
    if (b_fetch_ready !== 1'b0 || b_busy !== 1'b0 || b_load_count !== 3'd0) begin
      errors++; $display("FAIL inflight_idle: got ready=%b busy=%b count=%0d, expected 0 0 0",
                         b_fetch_ready, b_busy, b_load_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_misalign();
    test_full();
    test_drain();
    test_simultaneous();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Parametrised instruction memory with two ports: a streaming load port that fills the array from a boot source or bench, and a pipelined, handshaked fetch port that serves the CPU. It replaces the fixed single-port instruction ROM. New behaviour:

- configurable width, depth and read latency
- explicit load/run modes with a drain step between them
- per-fetch error reporting for misaligned or never-loaded addresses

## Interface

Parameters:
- DATA_W, 32, instruction word width in bits
- DEPTH, 256, number of words; power of two, at least 4
- ADDR_W, 32, fetch byte-address width
- READ_LAT, 1, fetch response latency in cycles; legal range 1..4

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse; opens a load session with the write pointer at word 0
- load_valid  in  1  load_data holds a word to write
- load_data  in  DATA_W  word written at the current pointer
- load_ready  out  1  high in LOAD while pointer < DEPTH
- load_done  in  1  pulse; closes the load session
- load_count  out  $clog2(DEPTH)+1  number of words loaded in the last or current session
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address (PC)
- fetch_ready  out  1  high only in RUN
- fetch_valid  out  1  one-cycle response strobe
- fetch_inst  out  DATA_W  fetched word; 0 when fetch_err is high
- fetch_err  out  1  the response is an error
- busy  out  1  high in LOAD or DRAIN

## Operation

The block has four states: IDLE, LOAD, RUN and DRAIN.

- **IDLE** (entered on reset):
  - fetch_ready=0, load_ready=0.
  - load_start moves the block to LOAD.
- **LOAD:**
  - Entry on load_start sets pointer=0 and load_count=0.
  - A beat is accepted when load_valid && load_ready. It writes mem[pointer]=load_data and increments both pointer and load_count.
  - When pointer reaches DEPTH, load_ready falls. Further load_valid is ignored and the block stays in LOAD.
  - load_done moves the block to RUN. If load_valid is also high that cycle, the beat is written first.
  - load_start while already in LOAD restarts the session: pointer and load_count return to 0.
- **RUN:**
  - fetch_ready=1. A request is accepted when fetch_req && fetch_ready. The block is fully pipelined and accepts one request per cycle.
  - The word index is fetch_addr >> 2, using bits [$clog2(DEPTH)+1:2].
  - Error conditions:
    - fetch_addr[1:0] != 0 gives an error.
    - A word index >= load_count gives an error.
    - Any address bits above the index range being nonzero gives an error.
  - An error response has fetch_err=1 and fetch_inst=0. A good response has fetch_err=0 and fetch_inst=mem[index].
  - The fetch port has no backpressure; every accepted request produces exactly one response.
- **DRAIN:**
  - load_start in RUN goes to LOAD directly if the fetch pipeline is empty, otherwise to DRAIN.
  - In DRAIN, fetch_ready=0. In-flight responses complete normally, then the block enters LOAD with pointer=0.
- load_done outside LOAD is ignored. load_start in DRAIN is ignored (the pending load proceeds).
- Memory contents are not reset. The response pipeline and all control state are reset.

## Timing

- **Reset values:** state=IDLE; load_ready, fetch_ready, fetch_valid, fetch_err, busy = 0; fetch_inst = 0; load_count = 0; pipeline valid bits cleared.
- **Reset mid-operation:** a reset in any state, including mid-load or with fetches in flight, returns to IDLE immediately. In-flight responses are discarded and never appear.
- **Load beat:** an accepted beat at edge t makes the write and the load_count increment visible after edge t.
- **Load-to-fetch:** a word written at edge t is fetchable by a request accepted at edge t+1 or later (RUN must be entered first).
- **Fetch latency:** a request accepted at edge t has its response (fetch_valid, fetch_inst, fetch_err) visible in the cycle after edge t+READ_LAT-1, i.e. READ_LAT=1 gives the response in the next cycle.
- **Mode transitions:**
  - load_start in RUN with an empty pipeline gives LOAD after one edge.
  - Otherwise DRAIN lasts at most READ_LAT cycles.
  - load_done gives RUN after one edge; fetch_ready is high in the following cycle.
- **Outputs:** all outputs are registered, except load_ready, fetch_ready and busy, which decode from state and pointer.

## Test plan

- **Reset:** assert rst_n=0 mid-LOAD after 3 beats -> IDLE; load_count=0; fetch_valid stays 0 for 10 cycles; fetch_ready=0.
- **Load and fetch (DEPTH=256, READ_LAT=1):**
  - Stimulus: load 0x00500093, 0x00100113, 0x002081B3; load_done; fetch addr 0, 4, 8 on consecutive cycles.
  - Response: three back-to-back responses with matching words and fetch_err=0.
  - Then fetch addr 12 -> fetch_err=1, fetch_inst=0.
- **Misalignment:** fetch 0x6 -> err=1. Fetch 0x400 with DEPTH=256 -> err=1 (out of range).
- **Full (DEPTH=4):** load 5 beats -> load_ready low after beat 4; load_count=4; word 5 is dropped; load_done -> RUN.
- **Drain (READ_LAT=3):** two fetches in flight, then load_start -> DRAIN; both responses emerge at their scheduled cycles; then LOAD; fetch_ready=0 throughout.
- **Simultaneous events:** load_valid and load_done in the same cycle -> the last word is written, load_count includes it, and it is fetchable with err=0.
